// File: rtl/lpc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lpc_pkg
// Description : Shared constants, types and helpers for the LPC synthesis
//               (decode) block: Q-format widths, register map, FSM states,
//               LFSR taps and the output saturation function.
// Revision    : 1.0 - initial release
// ============================================================================
package lpc_pkg;

  // Q-format and filter geometry
  localparam int COEF_FRAC = 12;   // Q4.12 coefficients, 4096 = 1.0
  localparam int LPC_ORDER = 10;   // all-pole filter order
  localparam int ACC_W     = 40;   // MAC accumulator width
  localparam int EXC_W     = 17;   // excitation width (sign + 16-bit gain)

  // Register map
  localparam logic [15:0] ADDR_PITCH  = 16'h0000;
  localparam logic [15:0] ADDR_GAIN   = 16'h0001;
  localparam logic [15:0] ADDR_STATUS = 16'h0002;
  localparam logic [15:0] ADDR_HCLR   = 16'h0003;
  localparam logic [15:0] READ_BAD    = 16'h0BAD;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, right-shifting form:
  // feedback is the parity of bits 0, 2, 3 and 5, inserted at bit 15.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  // Saturation bounds expressed at accumulator width
  localparam logic signed [ACC_W-1:0] SAT_MAX = 40'sd32767;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -40'sd32768;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXC  = 2'd1,
    ST_MAC  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  // Rescale a Q.12-weighted accumulator to a Q1.15 sample, clamping instead
  // of wrapping so a runaway filter holds at full scale.
  function automatic logic signed [15:0] sat16(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> COEF_FRAC;
    if (s > SAT_MAX)
      return 16'sh7FFF;
    else if (s < SAT_MIN)
      return 16'sh8000;
    else
      return s[15:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/lpc_lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : lpc_lfsr16
// Description : 16-bit Fibonacci LFSR used as the unvoiced noise source.
//               Advances one position per cycle while step is high.
// Revision    : 1.0 - initial release
// ============================================================================
module lpc_lfsr16
  import lpc_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  output logic [15:0] lfsr
);

  // Shift right, feeding the tap parity back into the MSB
  always_ff @(posedge clk) begin
    if (rst)
      lfsr <= SEED;
    else if (step)
      lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
  end

endmodule
`default_nettype wire

// File: rtl/lpc_dec.sv
`default_nettype none
// ============================================================================
// Module      : lpc_dec
// Description : LPC synthesis filter. Latches predictor coefficients and the
//               voicing flag, builds a pitch-pulse or noise excitation per
//               sample strobe and runs a 10th-order all-pole filter through
//               one shared sequential MAC. Pitch, gain and status sit behind
//               a 16-bit register port.
// Revision    : 1.0 - initial release
// ============================================================================
module lpc_dec
  import lpc_pkg::*;
#(
  parameter logic [15:0] DEF_PITCH = 16'd80,
  parameter logic [15:0] DEF_GAIN  = 16'd4096,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] A0,
  input  logic signed [15:0] A1,
  input  logic signed [15:0] A2,
  input  logic signed [15:0] A3,
  input  logic signed [15:0] A4,
  input  logic signed [15:0] A5,
  input  logic signed [15:0] A6,
  input  logic signed [15:0] A7,
  input  logic signed [15:0] A8,
  input  logic signed [15:0] A9,
  input  logic signed [15:0] A10,
  input  logic               voiced,
  input  logic               load,
  input  logic               v,
  output logic signed [15:0] y,
  output logic               vout,
  input  logic [15:0]        address,
  input  logic               read,
  input  logic               write,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata
);

  state_t state, next_state;

  // Coefficient inputs gathered into an array; index i holds A(i+1)
  logic signed [15:0] a_in     [LPC_ORDER];
  logic signed [15:0] shadow_a [LPC_ORDER];
  logic signed [15:0] act_a    [LPC_ORDER];
  logic signed [15:0] hist     [LPC_ORDER];   // hist[i] = y[n-1-i]
  logic [15:0]        shadow_a0;
  logic               shadow_voiced;
  logic               act_voiced;

  logic signed [ACC_W-1:0] acc;
  logic [3:0]              k;
  logic [3:0]              k_idx;
  logic [15:0]             pitch;
  logic [15:0]             gain;
  logic [15:0]             pcnt;
  logic [15:0]             pcnt_inc;
  logic                    overrun;
  logic [15:0]             lfsr_q;

  logic                    accept;
  logic                    voiced_src;
  logic signed [EXC_W-1:0] gain_ext;
  logic signed [EXC_W-1:0] exc;
  logic signed [31:0]      prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic                    wr_pitch, wr_gain, wr_status, wr_hclr;
  logic                    ovr_set;

  assign a_in[0] = A1;
  assign a_in[1] = A2;
  assign a_in[2] = A3;
  assign a_in[3] = A4;
  assign a_in[4] = A5;
  assign a_in[5] = A6;
  assign a_in[6] = A7;
  assign a_in[7] = A8;
  assign a_in[8] = A9;
  assign a_in[9] = A10;

  // A load coinciding with an accepted strobe feeds the new set straight in
  assign voiced_src = load ? voiced : shadow_voiced;

  assign gain_ext = {1'b0, gain};
  assign pcnt_inc = pcnt + 16'd1;

  // Excitation uses the LFSR and pitch counter values before they advance
  always_comb begin
    exc = '0;
    if (act_voiced)
      exc = (pcnt == 16'd0) ? gain_ext : '0;
    else
      exc = lfsr_q[0] ? gain_ext : -gain_ext;
  end

  // One tap of the filter per MAC cycle
  assign k_idx    = k - 4'd1;
  assign prod     = act_a[k_idx] * hist[k_idx];
  assign prod_ext = {{(ACC_W-32){prod[31]}}, prod};

  assign wr_pitch  = write && (address == ADDR_PITCH);
  assign wr_gain   = write && (address == ADDR_GAIN);
  assign wr_status = write && (address == ADDR_STATUS);
  assign wr_hclr   = write && (address == ADDR_HCLR);
  assign ovr_set   = v && (state != ST_IDLE);

  lpc_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (state == ST_EXC),
    .lfsr (lfsr_q)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= next_state;
  end

  // FSM next-state logic: EXC for one cycle, MAC for LPC_ORDER, OUT for one
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (v) begin
          next_state = ST_EXC;
          accept     = 1'b1;
        end
      end
      ST_EXC:  next_state = ST_MAC;
      ST_MAC:  if (k == 4'(LPC_ORDER)) next_state = ST_OUT;
      ST_OUT:  next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Shadow coefficient set, written by load regardless of FSM state
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LPC_ORDER; i++) shadow_a[i] <= '0;
      shadow_a0     <= '0;
      shadow_voiced <= 1'b0;
    end else if (load) begin
      for (int i = 0; i < LPC_ORDER; i++) shadow_a[i] <= a_in[i];
      shadow_a0     <= A0;
      shadow_voiced <= voiced;
    end
  end

  // Active coefficient set, refreshed only when a sample starts
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LPC_ORDER; i++) act_a[i] <= '0;
      act_voiced <= 1'b0;
    end else if (accept) begin
      for (int i = 0; i < LPC_ORDER; i++) act_a[i] <= load ? a_in[i] : shadow_a[i];
      act_voiced <= voiced_src;
    end
  end

  // Sample datapath: excitation load, MAC, output and history update
  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      k    <= 4'd0;
      pcnt <= 16'd0;
      y    <= '0;
      vout <= 1'b0;
      for (int i = 0; i < LPC_ORDER; i++) hist[i] <= '0;
    end else begin
      vout <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Entering voiced speech restarts the pitch train on an impulse
          if (accept && voiced_src && !act_voiced)
            pcnt <= 16'd0;
          if (wr_hclr)
            for (int i = 0; i < LPC_ORDER; i++) hist[i] <= '0;
        end
        ST_EXC: begin
          acc <= {{(ACC_W-EXC_W-COEF_FRAC){exc[EXC_W-1]}}, exc, {COEF_FRAC{1'b0}}};
          k   <= 4'd1;
          if ((pitch <= 16'd1) || (pcnt_inc >= pitch))
            pcnt <= 16'd0;
          else
            pcnt <= pcnt_inc;
        end
        ST_MAC: begin
          acc <= acc - prod_ext;
          k   <= k + 4'd1;
        end
        ST_OUT: begin
          y       <= sat16(acc);
          vout    <= 1'b1;
          hist[0] <= sat16(acc);
          for (int i = 1; i < LPC_ORDER; i++) hist[i] <= hist[i-1];
        end
        default: ;
      endcase
    end
  end

  // Control registers; an overrun in the same cycle as a clear stays set
  always_ff @(posedge clk) begin
    if (rst) begin
      pitch   <= DEF_PITCH;
      gain    <= DEF_GAIN;
      overrun <= 1'b0;
    end else begin
      if (wr_pitch) pitch <= writedata;
      if (wr_gain)  gain  <= writedata;
      overrun <= ovr_set | (overrun & ~(wr_status & writedata[0]));
    end
  end

  // Registered read port; reads see the value before a same-cycle write
  always_ff @(posedge clk) begin
    if (rst)
      readdata <= '0;
    else if (read) begin
      case (address)
        ADDR_PITCH:  readdata <= pitch;
        ADDR_GAIN:   readdata <= gain;
        ADDR_STATUS: readdata <= {15'd0, overrun};
        ADDR_HCLR:   readdata <= 16'd0;
        default:     readdata <= READ_BAD;
      endcase
    end else
      readdata <= '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_lpc_dec.sv
`default_nettype none
// ============================================================================
// Module      : tb_lpc_dec
// Description : Directed self-checking bench for lpc_dec: register map table,
//               impulse train, one-pole decay, saturation, noise signs,
//               overrun, coefficient update timing and mid-sample reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lpc_dec;

  logic clk = 1'b0;
  logic rst;
  logic signed [15:0] A0, A1, A2, A3, A4, A5, A6, A7, A8, A9, A10;
  logic voiced, load, v, read, write;
  logic [15:0] address, writedata;
  logic signed [15:0] y;
  logic vout;
  logic [15:0] readdata;

  int tests = 0;
  int fails = 0;
  int vout_cnt = 0;

  always #5 clk = ~clk;

  lpc_dec dut (
    .clk(clk), .rst(rst),
    .A0(A0), .A1(A1), .A2(A2), .A3(A3), .A4(A4), .A5(A5),
    .A6(A6), .A7(A7), .A8(A8), .A9(A9), .A10(A10),
    .voiced(voiced), .load(load), .v(v),
    .y(y), .vout(vout),
    .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata)
  );

  // Count every output pulse so spurious ones can be detected
  always @(negedge clk) if (vout === 1'b1) vout_cnt++;

  typedef struct {
    bit          wr;
    bit          rd;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } reg_vec_t;

  task automatic check(input string nm, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; v = 1'b0; load = 1'b0; read = 1'b0; write = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic reg_wr(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic reg_rd(input logic [15:0] a, input logic [15:0] exp, input string nm);
    @(negedge clk);
    read = 1'b1; address = a;
    @(negedge clk);
    read = 1'b0;
    check(nm, {16'd0, readdata}, {16'd0, exp});
  endtask

  // Present A1 (others zero, A0 deliberately nonzero) and voiced; optionally pulse load
  task automatic set_coef(input logic signed [15:0] a1, input logic vd, input bit pulse);
    @(negedge clk);
    A0 = 16'sh7FFF; A1 = a1;
    {A2, A3, A4, A5, A6, A7, A8, A9, A10} = '0;
    voiced = vd;
    if (pulse) begin
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
    end
  endtask

  // One strobe; optional extra strobe or load pulse at a given cycle offset.
  // Checks latency 12 from the accepting edge and the sample value.
  task automatic send_sample(input logic signed [15:0] exp, input int extra_v_at,
                             input int load_at, input string nm);
    int lat;
    bit got;
    @(negedge clk);
    v = 1'b1;
    @(negedge clk);
    v = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      if (vout === 1'b1) got = 1'b1;
      else begin
        v    = (lat == extra_v_at);
        load = (lat == load_at);
        @(negedge clk);
        lat++;
      end
    end
    v = 1'b0;
    load = 1'b0;
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL %s: no vout within 40 cycles", nm);
    end else begin
      check({nm, " latency"}, lat, 12);
      check({nm, " y"}, y, exp);
    end
  endtask

  reg_vec_t rv [14];
  logic signed [15:0] exp_train [9];
  logic signed [15:0] exp_decay [6];
  logic signed [15:0] exp_sat   [4];

  initial begin
    int c0;
    logic [15:0] l;
    logic fb;

    rst = 1'b1; v = 1'b0; load = 1'b0; read = 1'b0; write = 1'b0;
    address = '0; writedata = '0; voiced = 1'b0;
    {A0, A1, A2, A3, A4, A5, A6, A7, A8, A9, A10} = '0;

    rv[0]  = '{wr:0, rd:1, addr:16'h0000, wdata:16'h0000, exp:16'd80};
    rv[1]  = '{wr:0, rd:1, addr:16'h0001, wdata:16'h0000, exp:16'd4096};
    rv[2]  = '{wr:0, rd:1, addr:16'h0002, wdata:16'h0000, exp:16'd0};
    rv[3]  = '{wr:0, rd:1, addr:16'h0007, wdata:16'h0000, exp:16'h0BAD};
    rv[4]  = '{wr:0, rd:1, addr:16'h0003, wdata:16'h0000, exp:16'd0};
    rv[5]  = '{wr:1, rd:0, addr:16'h0000, wdata:16'd1234, exp:16'd0};
    rv[6]  = '{wr:0, rd:1, addr:16'h0000, wdata:16'h0000, exp:16'd1234};
    rv[7]  = '{wr:1, rd:0, addr:16'h0007, wdata:16'h5555, exp:16'd0};
    rv[8]  = '{wr:0, rd:1, addr:16'h0007, wdata:16'h0000, exp:16'h0BAD};
    rv[9]  = '{wr:0, rd:1, addr:16'h0001, wdata:16'h0000, exp:16'd4096};
    rv[10] = '{wr:0, rd:1, addr:16'h0100, wdata:16'h0000, exp:16'h0BAD};
    rv[11] = '{wr:1, rd:1, addr:16'h0000, wdata:16'd77,   exp:16'd1234};
    rv[12] = '{wr:0, rd:1, addr:16'h0000, wdata:16'h0000, exp:16'd77};
    rv[13] = '{wr:0, rd:0, addr:16'h0000, wdata:16'h0000, exp:16'd0};

    exp_train = '{16'sd1000, 16'sd0, 16'sd0, 16'sd0, 16'sd1000,
                  16'sd0, 16'sd0, 16'sd0, 16'sd1000};
    exp_decay = '{16'sd8000, 16'sd4000, 16'sd2000, 16'sd1000, 16'sd500, 16'sd250};
    exp_sat   = '{16'sd20000, 16'sd32767, 16'sd32767, 16'sd32767};

    // ---- reset state and register map ----
    do_reset();
    check("reset y", y, 0);
    check("reset vout", {31'd0, vout}, 0);
    check("reset readdata", {16'd0, readdata}, 0);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      write = rv[i].wr; read = rv[i].rd;
      address = rv[i].addr; writedata = rv[i].wdata;
      @(negedge clk);
      write = 1'b0; read = 1'b0;
      if (rv[i].rd || !rv[i].wr)
        check($sformatf("regvec %0d", i), {16'd0, readdata}, {16'd0, rv[i].exp});
    end
    check("no vout after reset", vout_cnt, 0);

    // ---- voiced impulse train, pitch 4 ----
    do_reset();
    set_coef(16'sd0, 1'b1, 1'b1);
    reg_wr(16'h0000, 16'd4);
    reg_wr(16'h0001, 16'd1000);
    for (int i = 0; i < 9; i++) begin
      send_sample(exp_train[i], -1, -1, $sformatf("train %0d", i));
      repeat (7) @(negedge clk);
    end

    // ---- one pole at 0.5, then history clear ----
    do_reset();
    set_coef(-16'sd2048, 1'b1, 1'b1);
    reg_wr(16'h0000, 16'd100);
    reg_wr(16'h0001, 16'd8000);
    for (int i = 0; i < 6; i++)
      send_sample(exp_decay[i], -1, -1, $sformatf("decay %0d", i));
    reg_wr(16'h0003, 16'h1234);
    reg_rd(16'h0003, 16'd0, "hclr read");
    send_sample(16'sd0, -1, -1, "after hclr");

    // ---- saturating feedback ----
    do_reset();
    set_coef(-16'sd8192, 1'b1, 1'b1);
    reg_wr(16'h0000, 16'd100);
    reg_wr(16'h0001, 16'd20000);
    for (int i = 0; i < 4; i++)
      send_sample(exp_sat[i], -1, -1, $sformatf("sat %0d", i));

    // ---- unvoiced noise signs from the LFSR ----
    do_reset();
    set_coef(16'sd0, 1'b0, 1'b1);
    reg_wr(16'h0001, 16'd100);
    l = 16'hACE1;
    for (int i = 0; i < 8; i++) begin
      send_sample(l[0] ? 16'sd100 : -16'sd100, -1, -1, $sformatf("noise %0d", i));
      fb = l[0] ^ l[2] ^ l[3] ^ l[5];
      l = {fb, l[15:1]};
    end

    // ---- overrun, status clear, load during MAC ----
    do_reset();
    set_coef(16'sd0, 1'b1, 1'b1);
    reg_wr(16'h0000, 16'd1);
    reg_wr(16'h0001, 16'd1000);
    c0 = vout_cnt;
    send_sample(16'sd1000, 5, -1, "overrun sample");
    repeat (20) @(negedge clk);
    check("overrun vout count", vout_cnt - c0, 1);
    reg_rd(16'h0002, 16'd1, "status set");
    reg_wr(16'h0002, 16'd1);
    reg_rd(16'h0002, 16'd0, "status cleared");
    set_coef(-16'sd2048, 1'b1, 1'b0);
    send_sample(16'sd1000, -1, 4, "inflight unaffected");
    send_sample(16'sd1500, -1, -1, "new coef used");

    // ---- reset mid-sample ----
    @(negedge clk);
    v = 1'b1;
    @(negedge clk);
    v = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    c0 = vout_cnt;
    repeat (20) @(negedge clk);
    check("midreset no vout", vout_cnt - c0, 0);
    check("midreset y", y, 0);
    send_sample(16'sd4096, -1, -1, "post reset sample");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop in case a wait above never completes
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/lpc_dec.md
Name: lpc_dec

Overview:
LPC synthesis (decode) block: the receiving end of the LPC encoder's coefficient/voicing output.
- Latches predictor coefficients A0..A10 and the voiced flag.
- Generates an excitation per sample strobe: a pitch impulse train when voiced, a random ±gain sequence when unvoiced.
- Runs a 10th-order all-pole synthesis filter with one shared sequential MAC and emits one 16-bit sample per strobe.
- Pitch period, gain and status are reached over the same 16-bit Avalon-MM style register port as the encoder.

Parameters:
DEF_PITCH, 80, reset value of the pitch-period register (in samples)
DEF_GAIN, 4096, reset value of the gain register (excitation amplitude, Q1.15 sample units)
LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
A0..A10  in  16 each  signed predictor coefficients, Q4.12 (4096 = 1.0); A0 latched but not used in arithmetic
voiced  in  1  voicing decision accompanying the coefficients
load  in  1  one-cycle pulse; captures A1..A10 and voiced into the shadow set
v  in  1  sample strobe; requests one output sample
y  out  16  signed synthesized sample, Q1.15
vout  out  1  one-cycle pulse; y is valid in that cycle
address  in  16  register address
read  in  1  read strobe
write  in  1  write strobe
writedata  in  16  write data
readdata  out  16  registered read data

Behaviour:
- Reset values: y=0, vout=0, readdata=0. History y[n-1..n-10]=0. Shadow and active coefficients = 0, voiced = 0. pitch=DEF_PITCH, gain=DEF_GAIN, overrun=0, pitch counter=0, LFSR=LFSR_SEED, FSM=IDLE.
- Reset mid-operation: aborts the current sample, returns to IDLE and produces no vout.
- Coefficient loading: load writes the shadow set in any state. Shadow is copied to the active set only on IDLE->EXC, so coefficients never change mid-sample.
- If load and an accepted v occur in the same cycle, the new shadow values are used for that sample.
- FSM states: IDLE, EXC, MAC, OUT.
- IDLE: v=1 -> EXC, and copy shadow to active.
- EXC (1 cycle):
  - Form excitation e.
  - acc (40-bit signed) = sign-extended e << 12.
  - k=1.
  - Advance the LFSR and the pitch counter.
- MAC (10 cycles, k=1..10): acc <= acc - A_k * y[n-k], using a 16x16 signed product sign-extended to 40 bits. After k=10 -> OUT.
- OUT (1 cycle):
  - y <= sat16(acc >>> 12), saturating to [-32768, 32767].
  - Shift history: y[n-1] <= new y.
  - vout=1.
  - Next state: IDLE.
- Timing:
  - Accepted v in cycle t gives vout in cycle t+12.
  - Next v is accepted no earlier than cycle t+13.
- Overrun: v=1 in any state other than IDLE is ignored and sets the sticky overrun bit.
- Excitation when voiced:
  - e = gain if the pitch counter == 0, else 0.
  - The counter increments modulo pitch.
  - pitch=0 or 1 means an impulse every sample.
  - On an active-voiced 0->1 transition the counter restarts at 0, so the first voiced sample is an impulse.
- Excitation when unvoiced: e = +gain if LFSR bit0 = 1, else -gain.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1. Steps once per accepted sample regardless of voicing.
- Register map (readdata registered, 1-cycle latency, 0 when read=0):
  - 0x0: pitch, R/W.
  - 0x1: gain, R/W.
  - 0x2: status, bit0 = overrun; writing 1 to bit0 clears it. If an overrun occurs in the same cycle as the clear, set wins.
  - 0x3: write any value clears the history. Honoured only in IDLE; otherwise ignored. Reads return 0.
  - Other addresses: read returns 16'h0BAD, writes are discarded.
  - Read and write in the same cycle to the same address: read returns the old value.

Decomposition:
- Shared package lpc_pkg holds:
  - Q-format constants: COEF_FRAC=12, LPC_ORDER=10.
  - Register address constants.
  - FSM state enum.
  - LFSR tap constants.
- One natural sub-module, lpc_lfsr16: seed parameter, step enable, 16-bit state output.
- MAC, history shift register and FSM stay in lpc_dec.

Test Plan:
- Reset, then read 0x0, 0x1, 0x2, 0x7 -> 80, 4096, 0, 0x0BAD one cycle after each read. y=0, vout never asserted.
- All A=0, voiced=1 via load; write pitch=4, gain=1000; send 9 strobes spaced 20 cycles apart -> y = 1000,0,0,0,1000,0,0,0,1000, each vout exactly 12 cycles after its v.
- A1=-2048 (pole at 0.5), others 0, voiced=1, pitch=100, gain=8000 -> y = 8000,4000,2000,1000,500,250.
- A1=-8192 (gain 2 feedback), gain=20000, pitch=100 -> y = 20000, then 32767 held (saturated), no wrap to negative.
- Unvoiced, A=0, gain=100 -> every y is +/-100, with signs matching the LFSR bit0 sequence from seed 0xACE1.
- v pulsed 5 cycles after an accepted v -> no extra vout, status reads 1. Write 1 to 0x2 -> reads 0. Load pulsed during MAC -> the in-flight sample is unaffected and the next sample uses the new coefficients.
